// File: rtl/uart_frame_reporter.sv
// uart_frame_reporter: snapshots CHANNELS words of DATA_W bits on a period tick or manual
// trigger and sends them as one 8N1 UART burst: header, sequence byte, data bytes (channel 0
// first, LSB first), then an optional XOR checksum byte.
// Optional feature macro: UART_FRAME_REPORTER_CHECKSUM_EN appends the checksum byte.
module uart_frame_reporter #(
    parameter int unsigned MAINCLOCK = 50000000,
    parameter int unsigned BAUDRATE  = 115200,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned PERIOD    = 50000000,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_trigger,
    input  logic [CHANNELS*DATA_W-1:0]   i_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_overrun,
    output logic [7:0]                   o_seq,
    output logic                         o_tx
);

    localparam int unsigned CLKS_PER_BIT = MAINCLOCK / BAUDRATE;
    localparam int unsigned DATA_BYTES   = CHANNELS * DATA_W / 8;
`ifdef UART_FRAME_REPORTER_CHECKSUM_EN
    localparam int unsigned CSUM_BYTES   = 1;
`else
    localparam int unsigned CSUM_BYTES   = 0;
`endif
    localparam int unsigned NBYTES       = 2 + DATA_BYTES + CSUM_BYTES;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W       = $clog2(NBYTES);
    localparam int unsigned PER_W        = $clog2(PERIOD);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                       state_q, state_d;
    logic [BAUD_W-1:0]            baud_q, baud_d;
    logic [2:0]                   bit_q, bit_d;
    logic [BYTE_W-1:0]            byte_q, byte_d;
    logic [PER_W-1:0]             per_q, per_d;
    logic [CHANNELS*DATA_W-1:0]   shadow_q, shadow_d;
    logic [7:0]                   fseq_q, fseq_d;
    logic [7:0]                   seq_q, seq_d;
    logic                         tx_q, tx_d;
    logic                         done_q, done_d;
    logic                         overrun_q, overrun_d;

    logic       tick, req, baud_end, last_byte;
    logic [7:0] tx_byte;

    assign tick      = i_enable && (per_q == PER_LAST);
    assign req       = tick || i_trigger;
    assign baud_end  = (baud_q == BAUD_LAST);
    assign last_byte = (byte_q == BYTE_LAST);

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one byte is START, eight DATA bits, STOP; bytes run back to back
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req) state_d = StStart;
            StStart: if (baud_end) state_d = StData;
            StData:  if (baud_end && bit_q == 3'd7) state_d = StStop;
            StStop:  if (baud_end) state_d = last_byte ? StIdle : StStart;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers: counters, snapshot, sequence and pulse flags
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            baud_q    <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            per_q     <= '0;
            shadow_q  <= '0;
            fseq_q    <= '0;
            seq_q     <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            per_q     <= per_d;
            shadow_q  <= shadow_d;
            fseq_q    <= fseq_d;
            seq_q     <= seq_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Datapath next-state: period counter, baud/bit/byte counters, request capture
    always_comb begin
        per_d = per_q;
        if (i_enable) begin
            per_d = (per_q == PER_LAST) ? '0 : per_q + PER_W'(1);
        end

        baud_d = (state_q == StIdle || baud_end) ? '0 : baud_q + BAUD_W'(1);

        bit_d = bit_q;
        if (state_q == StStart) begin
            bit_d = '0;
        end else if (state_q == StData && baud_end) begin
            bit_d = bit_q + 3'd1;
        end

        byte_d = byte_q;
        if (state_q == StIdle) begin
            byte_d = '0;
        end else if (state_q == StStop && baud_end && !last_byte) begin
            byte_d = byte_q + BYTE_W'(1);
        end

        shadow_d = shadow_q;
        fseq_d   = fseq_q;
        if (state_q == StIdle && req) begin
            shadow_d = i_data;
            fseq_d   = seq_q;
        end

        done_d    = (state_q == StStop) && baud_end && last_byte;
        seq_d     = done_d ? seq_q + 8'd1 : seq_q;
        // A coincident tick and trigger is one request, so it can never overrun itself
        overrun_d = req && (state_q != StIdle);
    end

    // Output logic: pick the frame byte for the upcoming cycle and register the line level
    always_comb begin
        tx_byte = HEADER;
        if (byte_d == BYTE_W'(1)) begin
            tx_byte = fseq_q;
        end
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (byte_d == BYTE_W'(i + 2)) begin
                tx_byte = shadow_q[i*8 +: 8];
            end
        end
`ifdef UART_FRAME_REPORTER_CHECKSUM_EN
        if (byte_d == BYTE_LAST) begin
            tx_byte = HEADER ^ fseq_q;
            for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                tx_byte = tx_byte ^ shadow_q[i*8 +: 8];
            end
        end
`endif

        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = tx_byte[bit_d];
            default: tx_d = 1'b1;
        endcase

        o_busy    = (state_q != StIdle);
        o_done    = done_q;
        o_overrun = overrun_q;
        o_seq     = seq_q;
        o_tx      = tx_q;
    end

endmodule

// File: tb/tb_uart_frame_reporter.sv
// Bench for uart_frame_reporter: a byte-list model pushes expected frames into queues, and
// independent monitors decode the UART line and watch o_done/o_busy against them.
module tb_uart_frame_reporter;

    localparam int CPB    = 8;
    localparam int DW     = 16;
    localparam int CH     = 2;
    localparam int PER    = 1000;
    localparam int DBYTES = CH * DW / 8;
`ifdef UART_FRAME_REPORTER_CHECKSUM_EN
    localparam int NB     = 2 + DBYTES + 1;
`else
    localparam int NB     = 2 + DBYTES;
`endif
    localparam int FRAME_CYC = 10 * NB * CPB;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              trig;
    logic [CH*DW-1:0]  data;
    logic              busy;
    logic              done;
    logic              ovr;
    logic [7:0]        seq;
    logic              tx;

    always #5 clk = ~clk;

    uart_frame_reporter #(
        .MAINCLOCK (8),
        .BAUDRATE  (1),
        .DATA_W    (DW),
        .CHANNELS  (CH),
        .PERIOD    (PER),
        .HEADER    (8'hA5)
    ) dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_enable  (en),
        .i_trigger (trig),
        .i_data    (data),
        .o_busy    (busy),
        .o_done    (done),
        .o_overrun (ovr),
        .o_seq     (seq),
        .o_tx      (tx)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_bytes[$];
    logic [7:0] exp_seq[$];
    int         model_seq = 0;
    int         ov_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is simply the list of bytes it must carry
    task automatic push_frame(input logic [CH*DW-1:0] d);
        logic [7:0] b[$];
        b.push_back(8'hA5);
        b.push_back(8'(model_seq));
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < DW / 8; k++) begin
                b.push_back(d[c*DW + k*8 +: 8]);
            end
        end
`ifdef UART_FRAME_REPORTER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (b[i]) x = x ^ b[i];
            b.push_back(x);
        end
`endif
        foreach (b[i]) exp_bytes.push_back(b[i]);
        model_seq = (model_seq + 1) % 256;
        exp_seq.push_back(8'(model_seq));
    endtask

    // Call at a negedge with the DUT idle (or in its done cycle)
    task automatic send(input logic [CH*DW-1:0] d);
        data = d;
        trig = 1'b1;
        push_frame(d);
        @(negedge clk);
        trig = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_start_bit", 32'(tx), 32'd0);
    endtask

    task automatic wait_done(input string name);
        int k;
        for (k = 0; k < 3 * FRAME_CYC; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 3 * FRAME_CYC) begin
            checks++;
            errors++;
            $display("FAIL %s: o_done not seen within %0d cycles", name, 3 * FRAME_CYC);
        end
    endtask

    task automatic advance_until(input logic lvl, input int budget, inout int n,
                                 input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            if (busy === lvl) break;
            @(negedge clk);
            n++;
        end
        if (k == budget) begin
            checks++;
            errors++;
            $display("FAIL %s: o_busy never reached %0d within %0d cycles", name, lvl, budget);
        end
    endtask

    // UART line decoder: samples mid-bit and scores every received byte
    initial begin
        int         rx_off;
        bit         rx_on;
        logic [7:0] rx_byte;
        logic       rx_start;
        logic       rx_stop;
        rx_on    = 1'b0;
        rx_off   = 0;
        rx_byte  = '0;
        rx_start = 1'b1;
        rx_stop  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                rx_on = 1'b0;
            end else begin
                if (!rx_on && tx === 1'b0) begin
                    rx_on  = 1'b1;
                    rx_off = 0;
                end
                if (rx_on) begin
                    if (rx_off % CPB == CPB / 2) begin
                        if (rx_off / CPB == 0) rx_start = tx;
                        else if (rx_off / CPB <= 8) rx_byte[rx_off/CPB - 1] = tx;
                        else rx_stop = tx;
                    end
                    rx_off++;
                    if (rx_off == 10 * CPB) begin
                        rx_on = 1'b0;
                        check("start_bit", 32'(rx_start), 32'd0);
                        check("stop_bit", 32'(rx_stop), 32'd1);
                        if (exp_bytes.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_byte: got 0x%0h expected none", rx_byte);
                        end else begin
                            check("frame_byte", 32'(rx_byte), 32'(exp_bytes.pop_front()));
                        end
                    end
                end
            end
        end
    end

    // Completion monitor: frame length, done/busy alignment, sequence advance, overruns
    initial begin
        int busy_len;
        busy_len = 0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                busy_len = 0;
            end else begin
                if (busy === 1'b1) busy_len++;
                if (done === 1'b1) begin
                    check("done_busy_low", 32'(busy), 32'd0);
                    check("frame_len", 32'(busy_len), 32'(FRAME_CYC));
                    if (exp_seq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got o_done=1 expected none");
                    end else begin
                        check("seq_after_done", 32'(seq), 32'(exp_seq.pop_front()));
                    end
                    busy_len = 0;
                end
                if (ovr === 1'b1) ov_count++;
            end
        end
    end

    initial begin
        int ov0;
        int n;
        rst  = 1'b1;
        en   = 1'b0;
        trig = 1'b0;
        data = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overrun", 32'(ovr), 32'd0);
        check("reset_seq", 32'(seq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed frame: ch0=0x1234, ch1=0xABCD
        send({16'hABCD, 16'h1234});
        wait_done("directed");
        check("directed_seq", 32'(seq), 32'd1);

        // Input changes mid-frame must not leak into the frame in flight
        repeat (3) @(negedge clk);
        send(CH*DW'($urandom));
        repeat (4) @(negedge clk);
        data = CH*DW'($urandom);
        wait_done("data_change");

        // Overrun while busy: one pulse, frame unaffected
        repeat (2) @(negedge clk);
        ov0 = ov_count;
        send(CH*DW'($urandom));
        repeat (99) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        check("overrun_pulse", 32'(ovr), 32'd1);
        @(negedge clk);
        check("overrun_one_cycle", 32'(ovr), 32'd0);
        wait_done("overrun");
        check("overrun_count", 32'(ov_count - ov0), 32'd1);

        // Random frames; the first is issued in the done cycle (back-to-back)
        ov0 = ov_count;
        for (int i = 0; i < 6; i++) begin
            if (i != 0 && $urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end
            send(CH*DW'($urandom));
            wait_done("random");
        end
        check("random_no_overrun", 32'(ov_count - ov0), 32'd0);

        // Reset mid-frame aborts without o_done, sequence restarts at 0
        repeat (3) @(negedge clk);
        send(CH*DW'($urandom));
        repeat (199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_bytes.delete();
        exp_seq.delete();
        model_seq = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(CH*DW'($urandom));
        wait_done("after_abort");

        // Period ticks: frames at 1000 and 2000 cycles, then a coincident tick + trigger
        @(negedge clk);
        rst = 1'b1;
        model_seq = 0;
        repeat (2) @(negedge clk);
        data = CH*DW'($urandom);
        push_frame(data);
        push_frame(data);
        ov0 = ov_count;
        rst = 1'b0;
        en  = 1'b1;
        n   = 0;
        advance_until(1'b1, 1500, n, "tick0_rise");
        check("tick0_start_cycle", 32'(n), 32'd1000);
        advance_until(1'b0, 1500, n, "tick0_fall");
        advance_until(1'b1, 1500, n, "tick1_rise");
        check("tick1_start_cycle", 32'(n), 32'd2000);
        advance_until(1'b0, 1500, n, "tick1_fall");
        while (n < 2999) begin
            @(negedge clk);
            n++;
        end
        push_frame(data);
        trig = 1'b1;
        @(negedge clk);
        n++;
        trig = 1'b0;
        en   = 1'b0;
        check("tick_trig_busy", 32'(busy), 32'd1);
        check("tick_trig_no_overrun", 32'(ovr), 32'd0);
        wait_done("tick_trig");
        check("period_no_overrun", 32'(ov_count - ov0), 32'd0);
        check("period_seq", 32'(seq), 32'd3);

        repeat (5) @(negedge clk);
        check("leftover_bytes", 32'(exp_bytes.size()), 32'd0);
        check("leftover_seq", 32'(exp_seq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_reporter.md
# uart_frame_reporter

Parametrised periodic telemetry transmitter. It snapshots `CHANNELS` data words of `DATA_W` bits on a programmable period tick or a manual trigger, and serialises them as one framed UART burst (8N1, LSB first). The frame carries a header, a sequence number, the data bytes and an optional checksum. The block sits between kernel-level counters/status registers and the board `tx` pin, and replaces the fixed 64-bit single-word sender plus external period counter.

## Interface
- `MAINCLOCK`, 50000000: `i_clock` frequency in Hz.
- `BAUDRATE`, 115200: line rate. `CLKS_PER_BIT = MAINCLOCK/BAUDRATE`, truncated, must be ≥ 2.
- `DATA_W`, 64: bits per channel. Must be a multiple of 8, range 8..256.
- `CHANNELS`, 4: number of channels, range 1..16.
- `PERIOD`, 50000000: clocks between automatic ticks, ≥ 2.
- `HEADER`, 8'hA5: first byte of every frame.

Ports:
- `i_clock`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  enables the period counter. When low, the counter holds and no automatic ticks occur.
- `i_trigger`  in  1  single-cycle manual frame request.
- `i_data`  in  `CHANNELS*DATA_W`  channel words. Channel k occupies `[k*DATA_W +: DATA_W]`.
- `o_busy`  out  1  high while a frame is in flight.
- `o_done`  out  1  one-cycle pulse at frame completion.
- `o_overrun`  out  1  one-cycle pulse when a request is dropped.
- `o_seq`  out  8  sequence number of the next frame.
- `o_tx`  out  1  UART line, idle high.

## Operation
- Request = period tick OR `i_trigger`. A simultaneous tick and trigger form one request and produce one frame, with no overrun.
- Period counter counts 0..PERIOD-1 while `i_enable` is high. The tick fires in the cycle the count equals PERIOD-1; the counter then wraps to 0.
- A request in IDLE is accepted:
  - `i_data` is captured into a shadow register on that edge.
  - `o_seq` is captured as the frame's sequence byte.
  - Later changes to `i_data` do not affect the frame in flight.
- A request while busy is dropped and `o_overrun` pulses in the following cycle. The frame in flight is unaffected.
- Frame byte order:
  1. `HEADER`.
  2. Sequence byte.
  3. Channel 0 bytes, LSB first, then channel 1, and so on through channel `CHANNELS-1`.
  4. Checksum byte, only if enabled.
- `NBYTES = 2 + CHANNELS*DATA_W/8 (+1)`.
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1). There is no idle gap between bytes.
- FSM states:
  - IDLE: on request → START.
  - START: after `CLKS_PER_BIT` clocks → DATA.
  - DATA: after 8 bits → STOP.
  - STOP: after `CLKS_PER_BIT` clocks → START if bytes remain, else IDLE with `o_done` pulse.
- At completion, `o_seq` increments, mod 256 (0xFF wraps to 0x00).
- Counters: baud count `clog2(CLKS_PER_BIT)` bits, bit index 3 bits, byte index `clog2(NBYTES)` bits.

## Timing
- Reset values: `o_tx`=1, `o_busy`=0, `o_done`=0, `o_overrun`=0, `o_seq`=0. FSM returns to IDLE and the period counter clears to 0.
- Reset mid-frame aborts the frame. `o_tx` is 1 from the next edge and no `o_done` pulse is issued.
- With `i_enable` held high from reset release, the first tick occurs `PERIOD` cycles after reset is released.
- Request accepted at edge N:
  - `o_busy`=1 and `o_tx`=0 (start bit) from cycle N+1.
- Frame length is `10*NBYTES*CLKS_PER_BIT` cycles.
- At the end of the frame, `o_busy` falls and `o_done` pulses in the same cycle.
- A request in that done cycle is accepted, giving back-to-back frames.
- `o_tx` is registered, with no combinational path from inputs.

## Configuration
- `UART_FRAME_REPORTER_CHECKSUM_EN` defined: a trailing byte is appended, equal to the XOR of all preceding frame bytes, header and sequence included. `NBYTES` includes it.
- Not defined: no checksum byte. The frame ends after the last data byte.

## Test plan
Test parameters: `MAINCLOCK=8`, `BAUDRATE=1`, `DATA_W=16`, `CHANNELS=2`, `PERIOD=1000`; checksum enabled unless noted.
- Trigger with ch0=0x1234, ch1=0xABCD → line decodes A5 00 34 12 CD AB E5. `o_busy` lasts 560 cycles, `o_done` pulses once, `o_seq`=1.
- Same stimulus with the macro undefined → A5 00 34 12 CD AB, 480 cycles.
- `i_enable`=1, no trigger → frames start at cycles 1000 and 2000 after reset release, with sequence bytes 00 and 01.
- Trigger at busy+100 cycles → `o_overrun` pulses one cycle, and the frame in flight is bit-identical to the no-overrun run.
- Trigger, then `i_data` changed at cycle 5 → the transmitted bytes match the values captured at the trigger.
- `i_reset` asserted at cycle 200 of a frame → `o_tx`=1 and `o_busy`=0 next cycle, no `o_done`. The next trigger sends sequence byte 00.
